// File: rtl/countdown_pkg.sv
// Shared state encoding and default sizing for the countdown sequencer.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PRESCALE = 50_000_000;

endpackage

// File: rtl/countdown_sequencer_prescaler.sv
// Free-running prescaler: counts enabled cycles and flags the last one of each period.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk_50M,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] cnt_q;
  logic [PS_W-1:0] cnt_d;

  always_comb begin
    tick = en && (cnt_q == PS_W'(PRESCALE - 1));
  end

  // Clear wins over enable so a stop or a fresh load always restarts the period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PS_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Countdown controller: load, prescaled decrement, pause/stop and optional auto-reload.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk_50M,
  input  logic             Reset,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done_pulse,
  output logic [1:0]       state_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ps_en_s, ps_clr_s, tick_s;

  assign ps_en_s = (state_q == ST_RUN) && !pause && !stop;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk_50M (clk_50M),
    .Reset   (Reset),
    .en      (ps_en_s),
    .clr     (ps_clr_s),
    .tick    (tick_s)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    ps_clr_s = 1'b0;
    if (stop) begin
      state_d  = ST_IDLE;
      count_d  = '0;
      ps_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            reload_d = load_val;
            count_d  = load_val;
            ps_clr_s = 1'b1;
            if (load_val != '0) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick_s && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: begin
          ps_clr_s = 1'b1;
          // A zero reload would never count down, so it re-terminates every cycle.
          if (auto_reload && (reload_q != '0)) begin
            count_d = reload_q;
            state_d = ST_RUN;
          end else if (auto_reload) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            count_d = '0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_50M) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign count_out  = count_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign state_out  = state_q;

endmodule
